dadda_unsigned_multiplier_cla_8: RTL and testbench



---
 rtl/dadda_unsigned_multiplier_cla_8.sv | 148 ++++++++++++++
 tb/tb_dadda_unsigned_multiplier_cla_8.sv | 116 +++++++++++
 2 files changed

// File: rtl/dadda_unsigned_multiplier_cla_8.sv
// Unsigned 8x8 multiplier: AND-array partial products, Dadda reduction (8-6-4-3-2)
// and a 16-bit carry-lookahead final adder feeding a registered product.
module dadda_unsigned_multiplier_cla_8 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] product
);

    localparam int DATA_W  = 8;
    localparam int PROD_W  = 16;
    localparam int STAGES  = 4;

    logic [PROD_W-1:0] row_a_p0;
    logic [PROD_W-1:0] row_b_p0;
    logic [PROD_W-1:0] gen_p0;
    logic [PROD_W-1:0] prop_p0;
    logic [PROD_W-1:0] carry_p0;
    logic [PROD_W-1:0] sum_p0;

    // Dadda height targets after each reduction stage.
    function automatic int dadda_target(input int stage);
        case (stage)
            0:       return 6;
            1:       return 4;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    // Lookahead carries {c4, c3, c2, c1} of one 4-bit group from its carry-in.
    function automatic logic [3:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                                input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Stage p0: partial products and Dadda tree. Column bookkeeping is fully static,
    // so the loops unroll into a fixed network of half and full adders.
    always_comb begin : dadda_tree
        logic [PROD_W-1:0][DATA_W-1:0] col;
        logic [PROD_W-1:0][DATA_W-1:0] nxt;
        int cnt  [PROD_W];
        int ncnt [PROD_W];
        int idx;
        int total;
        int d;
        logic x, y, z, s, c;

        row_a_p0 = '0;
        row_b_p0 = '0;
        col      = '0;
        nxt      = '0;
        x = 1'b0; y = 1'b0; z = 1'b0; s = 1'b0; c = 1'b0;
        idx = 0; total = 0; d = 0;
        for (int k = 0; k < PROD_W; k++) begin
            cnt[k]  = 0;
            ncnt[k] = 0;
        end

        for (int i = 0; i < DATA_W; i++) begin
            for (int j = 0; j < DATA_W; j++) begin
                col[4'(i + j)][3'(cnt[i + j])] = A[j] & B[i];
                cnt[i + j] = cnt[i + j] + 1;
            end
        end

        for (int st = 0; st < STAGES; st++) begin
            d   = dadda_target(st);
            nxt = '0;
            for (int k = 0; k < PROD_W; k++) ncnt[k] = 0;

            for (int k = 0; k < PROD_W; k++) begin
                idx = 0;
                // Carries already placed in nxt[k] count toward this column's budget.
                for (int t = 0; t < DATA_W; t++) begin
                    total = ncnt[k] + cnt[k] - idx;
                    if (total > d) begin
                        x = col[4'(k)][3'(idx)];
                        y = col[4'(k)][3'(idx + 1)];
                        if (total - d == 1) begin
                            s   = x ^ y;
                            c   = x & y;
                            idx = idx + 2;
                        end else begin
                            z   = col[4'(k)][3'(idx + 2)];
                            s   = x ^ y ^ z;
                            c   = (x & y) | (x & z) | (y & z);
                            idx = idx + 3;
                        end
                        nxt[4'(k)][3'(ncnt[k])] = s;
                        ncnt[k] = ncnt[k] + 1;
                        if (k < PROD_W - 1) begin
                            nxt[4'(k + 1)][3'(ncnt[k + 1])] = c;
                            ncnt[k + 1] = ncnt[k + 1] + 1;
                        end
                    end
                end
                for (int t = 0; t < DATA_W; t++) begin
                    if (t >= idx && t < cnt[k]) begin
                        nxt[4'(k)][3'(ncnt[k])] = col[4'(k)][3'(t)];
                        ncnt[k] = ncnt[k] + 1;
                    end
                end
            end

            col = nxt;
            for (int k = 0; k < PROD_W; k++) cnt[k] = ncnt[k];
        end

        for (int k = 0; k < PROD_W; k++) begin
            row_a_p0[k] = (cnt[k] > 0) ? col[4'(k)][0] : 1'b0;
            row_b_p0[k] = (cnt[k] > 1) ? col[4'(k)][1] : 1'b0;
        end
    end

    assign gen_p0  = row_a_p0 & row_b_p0;
    assign prop_p0 = row_a_p0 ^ row_b_p0;

    // Lookahead inside each 4-bit group; group carries ripple between groups.
    // The final carry-out is never needed since 255*255 fits in 16 bits.
    always_comb begin : cla_adder
        logic [3:0] grp_c;
        carry_p0    = '0;
        carry_p0[0] = 1'b0;
        grp_c       = '0;
        for (int grp = 0; grp < PROD_W / 4; grp++) begin
            grp_c = cla4_carries(gen_p0[4*grp +: 4], prop_p0[4*grp +: 4], carry_p0[4*grp]);
            carry_p0[4*grp + 1 +: 3] = grp_c[2:0];
            if (grp < PROD_W / 4 - 1) carry_p0[4*grp + 4] = grp_c[3];
        end
    end

    assign sum_p0 = prop_p0 ^ carry_p0;

    // Stage p1: product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) product <= '0;
        else     product <= sum_p0;
    end

endmodule

// File: tb/tb_dadda_unsigned_multiplier_cla_8.sv
// Bench for dadda_unsigned_multiplier_cla_8: integer-product reference model checked
// every cycle, directed literal vectors, asynchronous reset and an exhaustive sweep.
module tb_dadda_unsigned_multiplier_cla_8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] product;

    int          total = 0;
    int          bad   = 0;
    int          shown = 0;
    logic [15:0] exp_q;

    always #5 clk = ~clk;

    dadda_unsigned_multiplier_cla_8 dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .product (product)
    );

    // Reference: a register holding the plain integer product, cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= 16'd0;
        else     exp_q <= 16'(A) * 16'(B);
    end

    always @(negedge clk) begin
        total++;
        if (product !== exp_q) begin
            bad++;
            if (shown < 20)
                $display("FAIL model_cmp t=%0t A=%0d B=%0d product=%0d expected=%0d",
                         $time, A, B, product, exp_q);
            shown++;
        end
    end

    task automatic check_lit(input string name, input logic [15:0] want);
        total++;
        if (product !== want) begin
            bad++;
            $display("FAIL %s product=%0d expected=%0d", name, product, want);
        end
        total++;
        if (exp_q !== want) begin
            bad++;
            $display("FAIL %s_model model=%0d expected=%0d", name, exp_q, want);
        end
    endtask

    localparam int NV = 10;
    logic [7:0]  va [NV] = '{8'd0, 8'd1, 8'd255, 8'd98, 8'd170, 8'd229, 8'd255, 8'd128, 8'd15, 8'd16};
    logic [7:0]  vb [NV] = '{8'd173, 8'd200, 8'd1, 8'd115, 8'd99, 8'd42, 8'd255, 8'd128, 8'd17, 8'd16};
    logic [15:0] ve [NV] = '{16'd0, 16'd200, 16'd255, 16'd11270, 16'd16830, 16'd9618,
                             16'd65025, 16'd16384, 16'd255, 16'd256};

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        A   = 8'hFF;
        B   = 8'hFF;
        repeat (3) @(posedge clk);
        #1 check_lit("reset_hold_a", 16'd0);
        @(posedge clk);
        #1 check_lit("reset_hold_b", 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 check_lit("reset_release", 16'd65025);

        // Back-to-back directed vectors, one per cycle.
        for (int i = 0; i < NV; i++) begin
            A = va[i];
            B = vb[i];
            @(posedge clk);
            #1 check_lit($sformatf("vec%0d", i), ve[i]);
        end

        // Reset asserted between edges must clear the output with no clock edge.
        A = 8'd200;
        B = 8'd200;
        @(posedge clk);
        #1 check_lit("pre_async", 16'd40000);
        #2 rst = 1'b1;
        #1 check_lit("async_clear", 16'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check_lit("post_async", 16'd40000);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                A = 8'(a);
                B = 8'(b);
                @(posedge clk);
                #1;
            end
        end
        check_lit("sweep_last", 16'd65025);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
